// File: rtl/ps2_key_event_queue_pkg.sv
// ps2_kbd_pkg: shared constants, event layout and FSM states for the PS/2 keyboard event queue.
// Holds prefix bytes, modifier/Pause keycodes, event field offsets and helpers.
package ps2_kbd_pkg;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_E1 = 8'hE1;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_AA = 8'hAA;

    localparam logic [6:0] KC_LCTRL  = 7'h01;
    localparam logic [6:0] KC_LSHFT  = 7'h02;
    localparam logic [6:0] KC_LALT   = 7'h03;
    localparam logic [6:0] KC_LWIN   = 7'h04;
    localparam logic [6:0] KC_RCTRL  = 7'h05;
    localparam logic [6:0] KC_RSHFT  = 7'h06;
    localparam logic [6:0] KC_RALT   = 7'h07;
    localparam logic [6:0] KC_RWIN   = 7'h08;
    localparam logic [6:0] KC_CAPS   = 7'h09;
    localparam logic [6:0] KC_NUMLCK = 7'h0A;
    localparam logic [6:0] KC_PAUSE  = 7'h10;

    localparam int EVT_W       = 19;
    localparam int EVT_REL_BIT = 18;
    localparam int EVT_MOD_LSB = 8;
    localparam int EVT_MOD_W   = 10;
    localparam int EVT_EXT_BIT = 7;
    localparam int EVT_KC_W    = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } state_t;

    // Controller/keyboard status bytes that carry no key information.
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == 8'hFA) || (b == 8'hEE) || (b == 8'hFE) ||
               (b == 8'h00) || (b == 8'hFF);
    endfunction

    function automatic logic [EVT_MOD_W-1:0] mods_of(input logic [127:0] bm);
        return {bm[KC_LCTRL], bm[KC_LSHFT], bm[KC_LALT], bm[KC_LWIN],
                bm[KC_RCTRL], bm[KC_RSHFT], bm[KC_RALT], bm[KC_RWIN],
                bm[KC_CAPS], bm[KC_NUMLCK]};
    endfunction

endpackage

// File: rtl/ps2_key_event_queue_if.sv
// Event read port: FWFT valid/ready handshake plus head data and occupancy.
// master = queue side (drives valid/data/count), slave = consumer (drives ready).
interface ps2_key_event_queue_if #(
    parameter int DEPTH = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             evt_valid;
    logic             evt_ready;
    logic [18:0]      evt_data;
    logic [CNT_W-1:0] evt_count;

    modport master (
        output evt_valid,
        output evt_data,
        output evt_count,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_data,
        input  evt_count,
        output evt_ready
    );
endinterface

// File: rtl/ps2_key_event_queue_lut.sv
// ps2_scancode_lut: combinational set-2 scancode to 7-bit keycode map.
// Ports: ext_i (E0 table select), code_i (scancode), key_o (keycode, 0 = unmapped).
module ps2_scancode_lut (
    input  logic       ext_i,
    input  logic [7:0] code_i,
    output logic [6:0] key_o
);

    always_comb begin
        key_o = 7'h00;
        case ({ext_i, code_i})
            9'h01C: key_o = 7'h4E;
            9'h032: key_o = 7'h4F;
            9'h021: key_o = 7'h50;
            9'h023: key_o = 7'h51;
            9'h024: key_o = 7'h52;
            9'h02B: key_o = 7'h53;
            9'h034: key_o = 7'h54;
            9'h033: key_o = 7'h55;
            9'h043: key_o = 7'h56;
            9'h03B: key_o = 7'h57;
            9'h042: key_o = 7'h58;
            9'h04B: key_o = 7'h59;
            9'h03A: key_o = 7'h5A;
            9'h031: key_o = 7'h5B;
            9'h044: key_o = 7'h5C;
            9'h04D: key_o = 7'h5D;
            9'h015: key_o = 7'h5E;
            9'h02D: key_o = 7'h5F;
            9'h01B: key_o = 7'h60;
            9'h02C: key_o = 7'h61;
            9'h03C: key_o = 7'h62;
            9'h02A: key_o = 7'h63;
            9'h01D: key_o = 7'h40;
            9'h022: key_o = 7'h41;
            9'h035: key_o = 7'h42;
            9'h01A: key_o = 7'h43;
            9'h016: key_o = 7'h21;
            9'h01E: key_o = 7'h22;
            9'h026: key_o = 7'h23;
            9'h025: key_o = 7'h24;
            9'h02E: key_o = 7'h25;
            9'h036: key_o = 7'h26;
            9'h03D: key_o = 7'h27;
            9'h03E: key_o = 7'h28;
            9'h046: key_o = 7'h29;
            9'h045: key_o = 7'h2A;
            9'h029: key_o = 7'h44;
            9'h05A: key_o = 7'h45;
            9'h066: key_o = 7'h46;
            9'h00D: key_o = 7'h47;
            9'h076: key_o = 7'h11;
            9'h014: key_o = 7'h01;
            9'h012: key_o = 7'h02;
            9'h011: key_o = 7'h03;
            9'h059: key_o = 7'h06;
            9'h058: key_o = 7'h09;
            9'h077: key_o = 7'h0A;
            9'h11F: key_o = 7'h04;
            9'h114: key_o = 7'h05;
            9'h111: key_o = 7'h07;
            9'h127: key_o = 7'h08;
            9'h175: key_o = 7'h64;
            9'h172: key_o = 7'h65;
            9'h16B: key_o = 7'h66;
            9'h174: key_o = 7'h67;
            9'h16C: key_o = 7'h68;
            9'h169: key_o = 7'h69;
            9'h17D: key_o = 7'h6A;
            9'h17A: key_o = 7'h6B;
            9'h170: key_o = 7'h6C;
            9'h171: key_o = 7'h6D;
            9'h15A: key_o = 7'h6E;
            9'h14A: key_o = 7'h6F;
            default: key_o = 7'h00;
        endcase
    end

endmodule

// File: rtl/ps2_key_event_queue.sv
// ps2_key_event_queue: PS/2 set-2 decoder, key bitmap and FWFT event FIFO.
// Ports: CLOCK_50/reset_n; rx_data/rx_valid byte input; query/query_pressed
// key probe; evt (interface: evt_valid/evt_ready/evt_data/evt_count);
// overflow/clr_overflow sticky drop flag. Optional: PS2_KBD_REPEAT_FILTER_EN.
module ps2_key_event_queue
    import ps2_kbd_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int PAUSE_SKIP = 7
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic [6:0] query,
    output logic       query_pressed,
    ps2_key_event_queue_if.master evt,
    output logic       overflow,
    input  logic       clr_overflow
);

    localparam int AW     = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int SKIP_W = (PAUSE_SKIP < 1) ? 1 : $clog2(PAUSE_SKIP + 1);

    state_t            state_q, state_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [127:0]      bitmap_q, bitmap_d;
    logic [EVT_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;

    logic             lut_ext;
    logic [6:0]       lut_kc;
    logic             mapped;
    logic             key_done, key_rel, pause_done, clr_map;
    logic             is_repeat, push, push_ok, pop, full;
    logic [EVT_W-1:0] evt_word;

    assign lut_ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    assign mapped  = (lut_kc != 7'h00);

    ps2_scancode_lut u_lut (
        .ext_i  (lut_ext),
        .code_i (rx_data),
        .key_o  (lut_kc)
    );

    always_comb begin
        state_d    = state_q;
        skip_d     = skip_q;
        key_done   = 1'b0;
        key_rel    = 1'b0;
        pause_done = 1'b0;
        clr_map    = 1'b0;
        if (rx_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    unique case (1'b1)
                        rx_data == SC_E0: state_d = ST_EXT;
                        rx_data == SC_F0: state_d = ST_BRK;
                        rx_data == SC_E1: begin
                            state_d = ST_PAUSE;
                            skip_d  = SKIP_W'(PAUSE_SKIP);
                        end
                        rx_data == SC_AA: clr_map = 1'b1;
                        is_ignored(rx_data): ;
                        default: key_done = 1'b1;
                    endcase
                end
                ST_EXT: begin
                    // A stray prefix restarts the sequence.
                    if (rx_data == SC_F0) begin
                        state_d = ST_EXT_BRK;
                    end else if (rx_data == SC_E0) begin
                        state_d = ST_EXT;
                    end else if (rx_data == SC_E1) begin
                        state_d = ST_PAUSE;
                        skip_d  = SKIP_W'(PAUSE_SKIP);
                    end else begin
                        key_done = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    key_done = 1'b1;
                    key_rel  = 1'b1;
                    state_d  = ST_IDLE;
                end
                ST_PAUSE: begin
                    skip_d = skip_q - SKIP_W'(1);
                    if (skip_q <= SKIP_W'(1)) begin
                        pause_done = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bitmap_d = bitmap_q;
        if (clr_map) begin
            bitmap_d = '0;
        end else if (key_done && mapped) begin
            bitmap_d[lut_kc] = ~key_rel;
        end
    end

`ifdef PS2_KBD_REPEAT_FILTER_EN
    // Bit already equals the new state: typematic repeat or stray break.
    assign is_repeat = (bitmap_q[lut_kc] != key_rel);
`else
    assign is_repeat = 1'b0;
`endif

    assign push = pause_done || (key_done && mapped && !is_repeat);

    // Modifiers reflect the bitmap after this event's own update.
    always_comb begin
        evt_word = '0;
        if (pause_done) begin
            evt_word[EVT_MOD_LSB +: EVT_MOD_W] = mods_of(bitmap_q);
            evt_word[EVT_KC_W-1:0]             = KC_PAUSE;
        end else begin
            evt_word[EVT_REL_BIT]              = key_rel;
            evt_word[EVT_MOD_LSB +: EVT_MOD_W] = mods_of(bitmap_d);
            evt_word[EVT_EXT_BIT]              = lut_ext;
            evt_word[EVT_KC_W-1:0]             = lut_kc;
        end
    end

    assign full    = (count_q == CNT_W'(DEPTH));
    assign pop     = evt.evt_ready && (count_q != '0);
    assign push_ok = push && (!full || pop);

    assign wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    assign rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    assign count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    // A drop in the same cycle as a clear leaves the flag set.
    assign ovf_d    = (push && !push_ok) ? 1'b1 :
                      (clr_overflow ? 1'b0 : ovf_q);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            skip_q   <= '0;
            bitmap_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            skip_q   <= skip_d;
            bitmap_q <= bitmap_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= evt_word;
        end
    end

    assign evt.evt_valid = (count_q != '0);
    assign evt.evt_count = count_q;
    assign evt.evt_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign query_pressed = bitmap_q[query];
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Bench for ps2_key_event_queue: directed cases then random byte streams,
// compared against a key-state/event-queue reference model.
module tb_ps2_key_event_queue;

    localparam int DEPTH = 4;
    localparam int NK    = 19;

    logic       clk;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [6:0] query;
    logic       query_pressed;
    logic       overflow;
    logic       clr_overflow;

    ps2_key_event_queue_if #(.DEPTH(DEPTH)) evt_if ();

    ps2_key_event_queue #(.DEPTH(DEPTH), .PAUSE_SKIP(7)) dut (
        .CLOCK_50      (clk),
        .reset_n       (reset_n),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .query         (query),
        .query_pressed (query_pressed),
        .evt           (evt_if),
        .overflow      (overflow),
        .clr_overflow  (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keys used by the bench: A B W Space 1 Enter, ten modifiers, Up Down KPEnter.
    logic [7:0] k_sc  [NK] = '{8'h1C, 8'h32, 8'h1D, 8'h29, 8'h16, 8'h5A,
                               8'h14, 8'h12, 8'h11, 8'h1F, 8'h14, 8'h59,
                               8'h11, 8'h27, 8'h58, 8'h77,
                               8'h75, 8'h72, 8'h5A};
    bit         k_ext [NK] = '{0, 0, 0, 0, 0, 0,
                               0, 0, 0, 1, 1, 0,
                               1, 1, 0, 0,
                               1, 1, 1};
    logic [6:0] k_kc  [NK] = '{7'h4E, 7'h4F, 7'h40, 7'h44, 7'h21, 7'h45,
                               7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06,
                               7'h07, 7'h08, 7'h09, 7'h0A,
                               7'h64, 7'h65, 7'h6E};

    int          n_chk;
    int          n_fail;
    logic [127:0] mbm;
    logic [18:0] mq [$];
    bit          movf;
    int          pop_mode;
    int          q_force;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] mods();
        return {mbm[7'h01], mbm[7'h02], mbm[7'h03], mbm[7'h04], mbm[7'h05],
                mbm[7'h06], mbm[7'h07], mbm[7'h08], mbm[7'h09], mbm[7'h0A]};
    endfunction

    task automatic key_model(input bit ext, input logic [6:0] kc,
                             input bit rel, output bit ev,
                             output logic [18:0] e);
        bit was;
        was = mbm[kc];
        mbm[kc] = !rel;
        e = {rel, mods(), ext, kc};
`ifdef PS2_KBD_REPEAT_FILTER_EN
        ev = (was != !rel);
`else
        ev = 1'b1;
`endif
    endtask

    // One clock: drive a byte (or idle), advance the model, check outputs.
    task automatic tick(input bit v, input logic [7:0] b, input bit ev,
                        input logic [18:0] e, input bit clr);
        bit rdy;
        bit pop;
        bit drop;
        rdy = (pop_mode == 2) ? ($urandom_range(0, 1) == 1) : (pop_mode == 1);
        rx_valid = v;
        rx_data = b;
        evt_if.evt_ready = rdy;
        clr_overflow = clr;
        if (q_force >= 0) query = 7'(q_force);
        else if ($urandom_range(0, 1) == 1) query = k_kc[$urandom_range(0, NK - 1)];
        else query = 7'($urandom_range(0, 127));
        pop = (mq.size() != 0) && rdy;
        drop = 1'b0;
        if (pop) void'(mq.pop_front());
        if (ev) begin
            if (mq.size() == DEPTH) drop = 1'b1;
            else mq.push_back(e);
        end
        if (drop) movf = 1'b1;
        else if (clr) movf = 1'b0;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        clr_overflow = 1'b0;
        evt_if.evt_ready = 1'b0;
        chk("count", 32'(evt_if.evt_count), 32'(mq.size()));
        chk("valid", 32'(evt_if.evt_valid), 32'(mq.size() != 0));
        chk("data", 32'(evt_if.evt_data),
            32'((mq.size() != 0) ? mq[0] : 19'h0));
        chk("overflow", 32'(overflow), 32'(movf));
        chk("query", 32'(query_pressed), 32'(mbm[query]));
    endtask

    task automatic send_key(input int i, input bit rel);
        bit ev;
        logic [18:0] e;
        if (k_ext[i]) tick(1, 8'hE0, 0, '0, 0);
        if (rel) tick(1, 8'hF0, 0, '0, 0);
        key_model(k_ext[i], k_kc[i], rel, ev, e);
        tick(1, k_sc[i], ev, e, 0);
    endtask

    task automatic send_raw(input bit ext, input bit rel, input logic [7:0] sc);
        if (ext) tick(1, 8'hE0, 0, '0, 0);
        if (rel) tick(1, 8'hF0, 0, '0, 0);
        tick(1, sc, 0, '0, 0);
    endtask

    task automatic send_pause();
        logic [7:0] tail [7] = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        tick(1, 8'hE1, 0, '0, 0);
        for (int i = 0; i < 6; i++) tick(1, tail[i], 0, '0, 0);
        tick(1, tail[6], 1, {1'b0, mods(), 1'b0, 7'h10}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        rx_valid = 1'b0;
        evt_if.evt_ready = 1'b0;
        clr_overflow = 1'b0;
        query = 7'h4E;
        #2;
        mbm = '0;
        mq.delete();
        movf = 1'b0;
        chk("rst_valid", 32'(evt_if.evt_valid), 32'h0);
        chk("rst_count", 32'(evt_if.evt_count), 32'h0);
        chk("rst_data", 32'(evt_if.evt_data), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_query", 32'(query_pressed), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        mbm = '0;
        movf = 1'b0;
        pop_mode = 0;
        q_force = -1;
        reset_n = 1'b0;
        rx_data = 8'h00;
        rx_valid = 1'b0;
        query = 7'h00;
        clr_overflow = 1'b0;
        evt_if.evt_ready = 1'b0;
        do_reset();

        // A make, then release.
        q_force = 7'h4E;
        send_key(0, 0);
        chk("a_make", 32'(evt_if.evt_data), 32'h0004E);
        chk("a_down", 32'(query_pressed), 32'h1);
        pop_mode = 1;
        tick(0, 8'h00, 0, '0, 0);
        pop_mode = 0;
        send_key(0, 1);
        chk("a_break", 32'(evt_if.evt_data), 32'h4004E);
        chk("a_up", 32'(query_pressed), 32'h0);
        pop_mode = 1;
        tick(0, 8'h00, 0, '0, 0);

        // Shift modifier and extended Up.
        send_key(7, 0);
        send_key(0, 0);
        chk("shift_a", 32'(evt_if.evt_data), 32'h1004E);
        send_key(16, 0);
        chk("ext_up", 32'(evt_if.evt_data), 32'h100E4);
        q_force = -1;

        // Overflow and full push+pop.
        do_reset();
        pop_mode = 0;
        for (int i = 0; i < 5; i++) send_key(i, 0);
        chk("ovf_count", 32'(evt_if.evt_count), 32'd4);
        chk("ovf_set", 32'(overflow), 32'h1);
        q_force = 7'h21;
        tick(0, 8'h00, 0, '0, 0);
        chk("fifth_down", 32'(query_pressed), 32'h1);
        q_force = -1;
        tick(0, 8'h00, 0, '0, 1);
        chk("ovf_clr", 32'(overflow), 32'h0);
        pop_mode = 1;
        send_key(5, 0);
        chk("full_pp_cnt", 32'(evt_if.evt_count), 32'd4);
        chk("full_pp_ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 5; i++) tick(0, 8'h00, 0, '0, 0);

        // Pause sequence.
        do_reset();
        pop_mode = 0;
        send_pause();
        chk("pause_evt", 32'(evt_if.evt_data), 32'h00010);
        q_force = 7'h10;
        tick(0, 8'h00, 0, '0, 0);
        chk("pause_nobit", 32'(query_pressed), 32'h0);
        q_force = -1;

        // Repeated E0 prefix, then AA clears the bitmap.
        pop_mode = 1;
        tick(1, 8'hE0, 0, '0, 0);
        send_key(16, 0);
        send_key(0, 0);
        mbm = '0;
        q_force = 7'h4E;
        tick(1, 8'hAA, 0, '0, 0);
        chk("aa_clear", 32'(query_pressed), 32'h0);
        q_force = -1;

        // Reset in the middle of a break sequence.
        tick(1, 8'hF0, 0, '0, 0);
        do_reset();
        pop_mode = 0;
        send_key(0, 0);
        chk("post_rst_make", 32'(evt_if.evt_data), 32'h0004E);

        // Typematic repeat and unmapped byte.
        do_reset();
        send_key(0, 0);
        send_key(0, 0);
`ifdef PS2_KBD_REPEAT_FILTER_EN
        chk("repeat_cnt", 32'(evt_if.evt_count), 32'd1);
`else
        chk("repeat_cnt", 32'(evt_if.evt_count), 32'd2);
`endif
        send_raw(0, 0, 8'h02);
        send_raw(1, 0, 8'h12);

        // Random traffic.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            int r;
            pop_mode = $urandom_range(0, 2);
            r = $urandom_range(0, 11);
            if (r <= 6) begin
                send_key($urandom_range(0, NK - 1), $urandom_range(0, 1) == 1);
            end else if (r == 7) begin
                send_pause();
            end else if (r == 8) begin
                logic [7:0] ign [5] = '{8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
                tick(1, ign[$urandom_range(0, 4)], 0, '0, 0);
            end else if (r == 9) begin
                send_raw($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                         8'h02);
            end else if (r == 10 && $urandom_range(0, 3) == 0) begin
                mbm = '0;
                tick(1, 8'hAA, 0, '0, 0);
            end else begin
                tick(0, 8'h00, 0, '0, $urandom_range(0, 3) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
